// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv front-end stream buffers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package conv_pkg;

  // A stream word is 8 signed int8 lanes.
  localparam int LANES   = 8;
  localparam int LANE_W  = 8;
  localparam int WORD_W  = LANES * LANE_W;

  // Width of the runtime stage-depth request.
  localparam int DEPTH_W = 8;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef lane_t [LANES-1:0]        word_t;

  // Bound a requested depth to [1, max_depth]; a zero depth would make the
  // pointer wrap condition unreachable, so it is promoted to 1.
  function automatic int clamp_depth(input int depth, input int max_depth);
    if (depth < 1) begin
      return 1;
    end
    if (depth > max_depth) begin
      return max_depth;
    end
    return depth;
  endfunction

endpackage

// File: rtl/delay_bank.sv
// One delay stage: DEPTH x WIDTH RAM, read asynchronously, written on clk.
// Latency: read is combinational at addr; a write lands on the next clk edge.
// Backpressure: none; we gates the write and the caller owns flow control.
//
// Ports:
//   clk     - clock
//   we      - write enable
//   addr    - shared read/write pointer
//   wr_dat  - word written at addr
//   rd_dat  - word currently stored at addr (pre-write value)
module delay_bank import conv_pkg::*; #(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_dat,
  output logic [WIDTH-1:0]  rd_dat
);

  // No reset on storage: stale entries are masked by the caller's fill tracking.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[addr];

endmodule

// File: rtl/multi_tap_delay_line.sv
// Multi-tap delay line: tap k presents the sample accepted k*D enabled cycles ago.
// Latency: tap 0 is one clock behind din; tap k adds k*D_lat enabled cycles.
// Backpressure: none; en=0 freezes every stage and drops out_strobe to 0.
//
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset (depth returns to 1)
//   clear      - synchronous stream restart; latches depth_cfg; beats en
//   depth_cfg  - requested stage depth D, clamped to [1, MAX_DEPTH]
//   en         - accept din and advance all stages
//   din        - input word
//   taps       - tap k at bits [k*WIDTH +: WIDTH]
//   tap_valid  - bit k set once tap k holds data from the current stream
//   out_strobe - taps updated on this edge (registered en)
module multi_tap_delay_line import conv_pkg::*; #(
  parameter int WIDTH     = WORD_W,
  parameter int MAX_DEPTH = 128,
  parameter int NUM_TAPS  = 3,
  parameter int DEPTH_W   = conv_pkg::DEPTH_W,
  parameter int FILL_W    = $clog2((NUM_TAPS-1)*MAX_DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [DEPTH_W-1:0]        depth_cfg,
  input  logic                      en,
  input  logic [WIDTH-1:0]          din,
  output logic [NUM_TAPS*WIDTH-1:0] taps,
  output logic [NUM_TAPS-1:0]       tap_valid,
  output logic                      out_strobe
);

  localparam int PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [PTR_W-1:0]          ptr;
  logic [PTR_W-1:0]          ptr_nxt;
  logic [FILL_W-1:0]         fill;
  logic [FILL_W-1:0]         fill_max;
  logic [DEPTH_W-1:0]        d_lat;
  logic                      advance;
  logic [NUM_TAPS-1:0]       tv_set;
  logic [NUM_TAPS*WIDTH-1:0] taps_nxt;

  // Bank k feeds tap k; bank k is written with what bank k-1 just read,
  // so the banks form one long shift chain addressed by a single pointer.
  logic [WIDTH-1:0] rd_dat [1:NUM_TAPS-1];
  logic [WIDTH-1:0] wr_dat [1:NUM_TAPS-1];

  // A clearing edge must not disturb memory ordering of the next stream's
  // writes, but it must not count as a sample either, so it gates the write.
  assign advance = en && !clear;

  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_bank
    if (k == 1) begin : g_first
      assign wr_dat[k] = din;
    end else begin : g_chain
      assign wr_dat[k] = rd_dat[k-1];
    end

    delay_bank #(
      .WIDTH  (WIDTH),
      .DEPTH  (MAX_DEPTH),
      .ADDR_W (PTR_W)
    ) u_bank (
      .clk    (clk),
      .we     (advance),
      .addr   (ptr),
      .wr_dat (wr_dat[k]),
      .rd_dat (rd_dat[k])
    );
  end

  // The pointer cycles over 0..D_lat-1 only, which is what sets the stage depth.
  assign ptr_nxt  = (DEPTH_W'(ptr) == d_lat - DEPTH_W'(1)) ? '0 : ptr + PTR_W'(1);
  assign fill_max = FILL_W'(NUM_TAPS-1) * FILL_W'(d_lat);

  always_comb begin
    taps_nxt = '0;
    taps_nxt[WIDTH-1:0] = din;
    for (int k = 1; k < NUM_TAPS; k++) begin
      taps_nxt[k*WIDTH +: WIDTH] = rd_dat[k];
    end
  end

  // Tap k becomes real once at least k*D_lat samples preceded this one.
  always_comb begin
    tv_set = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (fill >= FILL_W'(k) * FILL_W'(d_lat)) begin
        tv_set[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      fill       <= '0;
      d_lat      <= DEPTH_W'(1);
      taps       <= '0;
      tap_valid  <= '0;
      out_strobe <= 1'b0;
    end else if (clear) begin
      ptr        <= '0;
      fill       <= '0;
      d_lat      <= DEPTH_W'(clamp_depth(32'(depth_cfg), MAX_DEPTH));
      taps       <= '0;
      tap_valid  <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= en;
      if (en) begin
        ptr       <= ptr_nxt;
        fill      <= (fill >= fill_max) ? fill : fill + FILL_W'(1);
        taps      <= taps_nxt;
        tap_valid <= tap_valid | tv_set;
      end
    end
  end

endmodule

// File: tb/tb_multi_tap_delay_line.sv
`timescale 1ns/1ps
module tb_multi_tap_delay_line;

  localparam int W  = 64;
  localparam int NT = 3;
  localparam int MD = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [7:0]    depth_cfg = '0;
  logic          en = 1'b0;
  logic [W-1:0]  din = '0;
  logic [NT*W-1:0] taps;
  logic [NT-1:0] tap_valid;
  logic          out_strobe;

  multi_tap_delay_line #(
    .WIDTH     (W),
    .MAX_DEPTH (MD),
    .NUM_TAPS  (NT),
    .DEPTH_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .depth_cfg  (depth_cfg),
    .en         (en),
    .din        (din),
    .taps       (taps),
    .tap_valid  (tap_valid),
    .out_strobe (out_strobe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NT-1:0][W-1:0] t;
    logic [NT-1:0]        vld;
    logic [NT-1:0]        known;  // tap value is defined (valid, or zeroed)
  } exp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_d      = 1;      // model latched depth
  logic [W-1:0] hist[$];     // enabled samples since last clear/reset
  exp_t   sb[$];
  exp_t   cur;
  int     seq;

  task automatic check(input string tag, input logic [NT*W-1:0] got, input logic [NT*W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int model_clamp(input int d);
    if (d == 0) return 1;
    if (d > MD) return MD;
    return d;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.t = '0;
    e.vld = '0;
    e.known = '1;
    return e;
  endfunction

  task automatic model_restart(input int d);
    m_d = d;
    hist.delete();
    sb.delete();
    cur = zero_exp();
  endtask

  task automatic compare(input exp_t e, input string ctx);
    check({ctx, "_tap_valid"}, NT*W'(tap_valid), NT*W'(e.vld));
    for (int k = 0; k < NT; k++) begin
      if (e.known[k]) begin
        check($sformatf("%s_tap%0d", ctx, k), NT*W'(taps[k*W +: W]), NT*W'(e.t[k]));
      end
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [W-1:0] d, input logic [7:0] dc);
    exp_t nx;
    exp_t o;
    int   n;
    int   idx;
    @(negedge clk);
    en = e; clear = c; din = d; depth_cfg = dc;
    if (c) begin
      model_restart(model_clamp(int'(dc)));
    end else if (e) begin
      hist.push_back(d);
      n = hist.size();
      nx = '0;
      for (int k = 0; k < NT; k++) begin
        idx = n - k * m_d;
        if (idx >= 1) begin
          nx.vld[k]   = 1'b1;
          nx.known[k] = 1'b1;
          nx.t[k]     = hist[idx-1];
        end
      end
      sb.push_back(nx);
      cur = nx;
    end
    @(posedge clk);
    #1;
    check("out_strobe", NT*W'(out_strobe), NT*W'(e && !c));
    if (out_strobe) begin
      check("sb_nonempty", NT*W'(sb.size() > 0), NT*W'(1));
      if (sb.size() > 0) begin
        o = sb.pop_front();
        compare(o, "sb");
      end
    end else begin
      compare(cur, "hold");
    end
    en = 1'b0; clear = 1'b0;
  endtask

  initial begin
    cur = zero_exp();
    // Reset state
    #2;
    check("rst_taps", taps, '0);
    check("rst_tap_valid", NT*W'(tap_valid), '0);
    check("rst_strobe", NT*W'(out_strobe), '0);
    #6 rst = 1'b0;

    // 1: D=4, counting stream
    step(1'b0, 1'b1, '0, 8'd4);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, W'(i), 8'd0);
      if (i == 1) check("t1_vld_s1", NT*W'(tap_valid), NT*W'(3'b001));
      if (i == 5) check("t1_vld_s5", NT*W'(tap_valid), NT*W'(3'b011));
    end
    check("t1_taps_s9", taps, {64'd1, 64'd5, 64'd9});
    check("t1_vld_s9", NT*W'(tap_valid), NT*W'(3'b111));

    // 2: D=MAX_DEPTH, long run across several pointer wraps
    step(1'b0, 1'b1, '0, 8'd128);
    for (int i = 1; i <= 600; i++) step(1'b1, 1'b0, W'(i), 8'd0);
    check("t2_taps_600", taps, {64'd344, 64'd472, 64'd600});

    // 3: D=3 with ~40% enable duty and random data
    step(1'b0, 1'b1, '0, 8'd3);
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 99) < 40), 1'b0, {$urandom, $urandom}, 8'($urandom));
    end

    // 4: clear together with en mid-stream drops that sample
    step(1'b0, 1'b1, '0, 8'd4);
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, W'(i), 8'd0);
    step(1'b1, 1'b1, 64'hdead, 8'd2);
    check("t4_clear_taps", taps, '0);
    check("t4_clear_vld", NT*W'(tap_valid), '0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, W'(i), 8'd0);
    check("t4_taps_s5", taps, {64'd1, 64'd3, 64'd5});

    // 5: depth clamping, 0 -> 1 and 200 -> 128
    step(1'b0, 1'b1, '0, 8'd0);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, W'(i), 8'd0);
    check("t5_d1_taps", taps, {64'd4, 64'd5, 64'd6});
    step(1'b0, 1'b1, '0, 8'd200);
    for (int i = 1; i <= 260; i++) step(1'b1, 1'b0, W'(i), 8'd0);
    check("t5_d128_taps", taps, {64'd4, 64'd132, 64'd260});

    // 6: async reset mid-stream, then stream without clear at D=1
    step(1'b0, 1'b1, '0, 8'd4);
    seq = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, W'(seq), 8'd0);
      seq++;
    end
    en = 1'b1; din = W'(seq);
    #2 rst = 1'b1;
    #1;
    check("t6_async_taps", taps, '0);
    check("t6_async_vld", NT*W'(tap_valid), '0);
    check("t6_async_strobe", NT*W'(out_strobe), '0);
    rst = 1'b0;
    en = 1'b0;
    model_restart(1);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, W'(i + 100), 8'd9);
    check("t6_d1_taps", taps, {64'd103, 64'd104, 64'd105});

    check("sb_drained", NT*W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Hard bound on total runtime so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
